// File: rtl/image_block_reader_if.sv
// Signal bundle for image_block_reader: CSR slave, memory read master and stream source.
// The master modport is the reader's view; slave is the view of whatever surrounds it.
interface image_block_reader_if #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32
);
    logic [1:0]        csr_address;
    logic              csr_write;
    logic [31:0]       csr_writedata;
    logic              csr_read;
    logic [31:0]       csr_readdata;
    logic [ADDR_W-1:0] m_address;
    logic              m_chipselect;
    logic              m_write;
    logic [DATA_W-1:0] m_readdata;
    logic [DATA_W-1:0] st_data;
    logic              st_valid;
    logic              st_ready;
    logic              st_sop;
    logic              st_eop;

    modport master (
        input  csr_address, csr_write, csr_writedata, csr_read, m_readdata, st_ready,
        output csr_readdata, m_address, m_chipselect, m_write, st_data, st_valid, st_sop, st_eop
    );

    modport slave (
        output csr_address, csr_write, csr_writedata, csr_read, m_readdata, st_ready,
        input  csr_readdata, m_address, m_chipselect, m_write, st_data, st_valid, st_sop, st_eop
    );
endinterface

// File: rtl/image_block_reader.sv
// Streams a contiguous block of words from pixel memory into an Avalon-ST source,
// buffered by a small fall-through FIFO so the downstream side can apply backpressure.
module image_block_reader #(
    parameter int ADDR_W     = 14,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 reset,
    image_block_reader_if.master bus
);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int LEN_W = 15;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_nextState;

    logic [ADDR_W-1:0] r_base;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_length;
    logic [LEN_W-1:0]  r_remaining;
    logic [LEN_W-1:0]  r_beatCount;
    logic              r_inflight;
    logic              r_done;
    logic              r_aborted;
    logic [31:0]       r_csrReaddata;
    logic [DATA_W-1:0] r_fifoMem [FIFO_DEPTH];
    logic [PTR_W-1:0]  r_wrPtr;
    logic [PTR_W-1:0]  r_rdPtr;
    logic [CNT_W-1:0]  r_fifoCount;

    logic              w_busy;
    logic              w_ctrlWrite;
    logic              w_start;
    logic              w_abort;
    logic              w_flush;
    logic              w_issue;
    logic              w_fifoEmpty;
    logic              w_stValid;
    logic              w_beat;
    logic              w_sop;
    logic              w_eop;
    logic              w_eopBeat;
    logic              w_push;
    logic              w_pop;
    logic [31:0]       w_statusWord;
    logic [31:0]       w_readValue;
    logic              w_unused;

    assign w_busy      = (r_state != IDLE);
    assign w_ctrlWrite = bus.csr_write && (bus.csr_address == 2'd2);
    assign w_abort     = w_ctrlWrite && bus.csr_writedata[1];
    assign w_start     = w_ctrlWrite && bus.csr_writedata[0] && !bus.csr_writedata[1];
    assign w_flush     = w_abort && w_busy;
    assign w_fifoEmpty = (r_fifoCount == '0);

    // Outstanding words (buffered plus the one in flight) never exceed the FIFO depth.
    assign w_issue = (r_state == READ) && !w_abort && (r_remaining != '0) &&
                     ((int'(r_fifoCount) + int'(r_inflight)) < FIFO_DEPTH);

    // A word arriving into an empty FIFO is presented straight away.
    assign w_stValid = !w_fifoEmpty || r_inflight;
    assign w_beat    = w_stValid && bus.st_ready;
    assign w_sop     = w_stValid && (r_beatCount == '0);
    assign w_eop     = w_stValid && (LEN_W'(r_beatCount + 1'b1) == r_length);
    assign w_eopBeat = w_beat && w_eop;
    assign w_pop     = !w_fifoEmpty && bus.st_ready;
    assign w_push    = r_inflight && !(w_fifoEmpty && bus.st_ready);

    assign w_statusWord = {1'b0, r_beatCount, 13'd0, r_aborted, r_done, w_busy};
    assign w_unused     = &{1'b0, bus.csr_writedata[31:LEN_W]};

    assign bus.m_address    = r_addr;
    assign bus.m_chipselect = w_issue;
    assign bus.m_write      = 1'b0;
    assign bus.st_valid     = w_stValid;
    assign bus.st_sop       = w_sop;
    assign bus.st_eop       = w_eop;
    assign bus.st_data      = !w_fifoEmpty ? r_fifoMem[r_rdPtr] :
                              (r_inflight ? bus.m_readdata : '0);
    assign bus.csr_readdata = r_csrReaddata;

    always_comb begin
        w_readValue = '0;
        case (bus.csr_address)
            2'd0:    w_readValue = 32'(r_base);
            2'd1:    w_readValue = 32'(r_length);
            2'd3:    w_readValue = w_statusWord;
            default: w_readValue = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (w_start && (r_length != '0)) begin
                    w_nextState = READ;
                end
            end
            READ: begin
                if (w_abort) begin
                    w_nextState = IDLE;
                end else if (w_issue && (r_remaining == LEN_W'(1))) begin
                    w_nextState = DRAIN;
                end
            end
            DRAIN: begin
                if (w_abort || w_eopBeat) begin
                    w_nextState = IDLE;
                end
            end
            default: w_nextState = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifoMem[r_wrPtr] <= bus.m_readdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_base        <= '0;
            r_addr        <= '0;
            r_length      <= '0;
            r_remaining   <= '0;
            r_beatCount   <= '0;
            r_inflight    <= 1'b0;
            r_done        <= 1'b0;
            r_aborted     <= 1'b0;
            r_csrReaddata <= '0;
            r_wrPtr       <= '0;
            r_rdPtr       <= '0;
            r_fifoCount   <= '0;
        end else begin
            r_csrReaddata <= bus.csr_read ? w_readValue : '0;

            if (bus.csr_write && !w_busy) begin
                if (bus.csr_address == 2'd0) r_base <= bus.csr_writedata[ADDR_W-1:0];
                if (bus.csr_address == 2'd1) r_length <= bus.csr_writedata[LEN_W-1:0];
            end

            if (!w_busy && w_start) begin
                if (r_length != '0) begin
                    r_addr      <= r_base;
                    r_remaining <= r_length;
                    r_done      <= 1'b0;
                    r_aborted   <= 1'b0;
                    r_beatCount <= '0;
                end else begin
                    r_done <= 1'b1;
                end
            end

            // Abort drops the buffered words and ignores the word still coming back.
            if (w_flush) begin
                r_aborted   <= 1'b1;
                r_inflight  <= 1'b0;
                r_wrPtr     <= '0;
                r_rdPtr     <= '0;
                r_fifoCount <= '0;
            end else begin
                r_inflight <= w_issue;
                if (w_issue) begin
                    r_addr      <= r_addr + 1'b1;
                    r_remaining <= r_remaining - 1'b1;
                end
                if (w_push) r_wrPtr <= r_wrPtr + 1'b1;
                if (w_pop)  r_rdPtr <= r_rdPtr + 1'b1;
                case ({w_push, w_pop})
                    2'b10:   r_fifoCount <= r_fifoCount + 1'b1;
                    2'b01:   r_fifoCount <= r_fifoCount - 1'b1;
                    default: r_fifoCount <= r_fifoCount;
                endcase
                if (w_beat)    r_beatCount <= r_beatCount + 1'b1;
                if (w_eopBeat) r_done <= 1'b1;
            end
        end
    end
endmodule

// File: doc/image_block_reader.md
# image_block_reader

Avalon-MM read master plus Avalon-ST source that streams a contiguous block of 32-bit image words out of a processor's on-chip pixel memory. It drives the memory's slave port (word address, chipselect, fixed one-cycle read latency, no waitrequest). It buffers returned words in a small FIFO so a downstream filter or the peer processor's bridge can apply backpressure. A Nios core programs it through a four-register CSR slave and polls or reads the done status.

## Interface
Parameters:
- ADDR_W, 14, memory word-address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 32, memory and stream data width
- FIFO_DEPTH, 4, output buffer entries (power of two, ≥2)

Ports (one clock; reset is synchronous and active-high):
- clk  in  1  sole clock, all logic rising-edge
- reset  in  1  synchronous, active-high; clears all state
- csr_address  in  2  register select
- csr_write  in  1  CSR write strobe
- csr_writedata  in  32  CSR write data
- csr_read  in  1  CSR read strobe
- csr_readdata  out  32  CSR read data, valid the cycle after csr_read
- m_address  out  ADDR_W  memory word address
- m_chipselect  out  1  read request; one word per asserted cycle
- m_write  out  1  tied 0
- m_readdata  in  DATA_W  memory data, valid exactly 1 cycle after the request
- st_data  out  DATA_W  stream data
- st_valid  out  1  stream beat valid
- st_ready  in  1  downstream accept
- st_sop  out  1  first beat of block
- st_eop  out  1  last beat of block

## Operation
- CSR map:
  - 0 BASE: word address, low ADDR_W bits.
  - 1 LENGTH: words, 15 bits, 0..16384.
  - 2 CONTROL: write-only; bit0 START, bit1 ABORT; reads 0.
  - 3 STATUS: bit0 BUSY, bit1 DONE (sticky), bit2 ABORTED (sticky), bits[30:16] beats emitted in current/last block.
- BASE/LENGTH writes while BUSY are ignored; reads return the latched values.
- FSM states IDLE, READ, DRAIN:
  - IDLE->READ on START with LENGTH≠0. Clears DONE, ABORTED, count; latches addr=BASE, remaining=LENGTH.
  - START with LENGTH=0 sets DONE only.
  - READ issues a request (m_chipselect=1, m_address=addr) when remaining≠0 and fifo_count + inflight < FIFO_DEPTH. inflight is the 1-bit request-issued-last-cycle flag. On each request addr increments mod 2^ADDR_W and remaining decrements.
  - READ->DRAIN when the last request issues.
  - DRAIN->IDLE when the eop beat is accepted. Sets DONE; BUSY=0.
- Each returned word is written into the FIFO the cycle after its request. This must never overflow, guaranteed by the issue rule.
- Stream:
  - st_valid = FIFO non-empty; a beat transfers on st_valid & st_ready.
  - st_sop on the first beat of the block, st_eop on beat number LENGTH.
  - st_data is stable while st_valid & ~st_ready.
- ABORT (any state) returns to IDLE next cycle:
  - FIFO flushed, inflight word discarded, ABORTED=1, DONE unchanged.
  - ABORT in IDLE does nothing.
- START while BUSY is ignored. START and ABORT in the same write: ABORT wins.
- Addresses ≥ memory depth are not checked; the memory's response is returned unaltered.

## Timing
- Reset values: csr_readdata=0, m_address=0, m_chipselect=0, m_write=0, st_valid=0, st_sop=0, st_eop=0, st_data=0. State IDLE; all STATUS bits 0; BASE=LENGTH=0.
- START write accepted in cycle T:
  - First m_chipselect in T+1.
  - Word captured T+2; st_valid first high T+2.
- With st_ready held high, sustained throughput is 1 beat/cycle. A block of N words ends with the eop beat at T+N+1, and DONE is readable from T+N+2.
- With st_ready low, requests stop once FIFO_DEPTH words are buffered or in flight. Requests resume the cycle after a beat is accepted.
- Reset asserted mid-transfer: all outputs take their reset values on the next edge; no further requests.

## Test plan
- Memory word[i]=i, BASE=0x100, LENGTH=4, st_ready=1 -> m_address 0x100..0x103 on consecutive cycles; beats 0x100..0x103; sop on beat 1, eop on beat 4; STATUS reads 0x0004_0002.
- LENGTH=16, st_ready pattern 1,0,0 repeating -> 16 beats in order with no loss or duplication; at no cycle does buffered + inflight exceed 4; m_chipselect low whenever the FIFO is full.
- BASE=0x3FFE, LENGTH=4 -> addresses 0x3FFE, 0x3FFF, 0x0000, 0x0001.
- LENGTH=1 -> a single beat with sop=eop=1; LENGTH=0 -> no m_chipselect, STATUS=0x0000_0002 one cycle after START.
- LENGTH=16 with st_ready=0; ABORT after 3 requests -> next cycle st_valid=0, BUSY=0, ABORTED=1; a new START then streams from BASE with sop.
- START rewritten while BUSY and BASE rewritten mid-block -> the transfer is unaffected; reset pulsed mid-block -> all outputs 0 next cycle and STATUS=0.
